// File: rtl/align_shamt_pipe.sv
// align_shamt_pipe: two-stage FMA pre-alignment. Unpacks A/B/C, forms the
// product exponent and effective-subtract flag, then derives the clamped
// addend shift and C significand in the form the addend aligner consumes.
module align_shamt_pipe #(
  parameter int unsigned SIG_WIDTH   = 23,
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned EXP_BIAS    = 127,
  parameter int unsigned SHAMT_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH:0] a,
  input  logic [EXP_WIDTH+SIG_WIDTH:0] b,
  input  logic [EXP_WIDTH+SIG_WIDTH:0] c,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIG_WIDTH:0]           out_sig_a,
  output logic [SIG_WIDTH:0]           out_sig_b,
  output logic [SIG_WIDTH:0]           out_sig_c,
  output logic [SHAMT_WIDTH-1:0]       out_shamt,
  output logic [EXP_WIDTH+1:0]         out_exp_ab,
  output logic                         out_sign_ab,
  output logic                         out_eff_sub,
  output logic                         out_clamp_lo,
  output logic                         out_clamp_hi
);

  localparam int unsigned FW        = EXP_WIDTH + SIG_WIDTH + 1;
  localparam int unsigned MW        = SIG_WIDTH + 1;
  localparam int unsigned XW        = EXP_WIDTH + 2;
  localparam int unsigned RW        = EXP_WIDTH + 3;
  localparam int unsigned MAX_SHAMT = 3 * SIG_WIDTH + 2;
  localparam int unsigned SHAMT_OFS = SIG_WIDTH + 4;

  // Effective exponent: a zero field (zero/denormal) behaves as exponent 1.
  function automatic logic [EXP_WIDTH-1:0] exp_of(input logic [FW-1:0] x);
    logic [EXP_WIDTH-1:0] f;
    f = x[FW-2:SIG_WIDTH];
    return (f == '0) ? EXP_WIDTH'(1) : f;
  endfunction

  // Significand with the hidden bit restored (0 for zero/denormal).
  function automatic logic [MW-1:0] sig_of(input logic [FW-1:0] x);
    return {(x[FW-2:SIG_WIDTH] != '0), x[SIG_WIDTH-1:0]};
  endfunction

  logic                 v1, v2;
  logic                 adv1, adv2;
  logic [MW-1:0]        s1_sig_a, s1_sig_b, s1_sig_c;
  logic                 s1_sign_ab, s1_eff_sub;
  logic [EXP_WIDTH-1:0] s1_ec;
  logic [XW-1:0]        s1_exp_ab;
  logic [XW-1:0]        exp_ab_c;
  logic [RW-1:0]        raw_c;
  logic [SHAMT_WIDTH-1:0] shamt_c;
  logic                 clamp_lo_c, clamp_hi_c;

  // Handshake: a stage advances when it is empty or the one after it advances.
  always_comb begin
    adv2     = !v2 || out_ready;
    adv1     = !v1 || adv2;
    in_ready = adv1;
  end

  // Product exponent eA+eB-bias; XW bits hold the full signed range.
  always_comb begin
    exp_ab_c = XW'(exp_of(a)) + XW'(exp_of(b)) - XW'(EXP_BIAS);
  end

  // Raw addend shift and its clamp into the aligner's supported range.
  always_comb begin
    raw_c      = RW'(s1_ec) - {s1_exp_ab[XW-1], s1_exp_ab} + RW'(SHAMT_OFS);
    shamt_c    = raw_c[SHAMT_WIDTH-1:0];
    clamp_lo_c = 1'b0;
    clamp_hi_c = 1'b0;
    if (raw_c[RW-1]) begin
      shamt_c    = '0;
      clamp_lo_c = 1'b1;
    end else if (raw_c > RW'(MAX_SHAMT)) begin
      shamt_c    = SHAMT_WIDTH'(MAX_SHAMT);
      clamp_hi_c = 1'b1;
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  // Stage 1: unpacked operands and product exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sig_a   <= '0;
      s1_sig_b   <= '0;
      s1_sig_c   <= '0;
      s1_sign_ab <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_ec      <= '0;
      s1_exp_ab  <= '0;
    end else if (in_valid && adv1) begin
      s1_sig_a   <= sig_of(a);
      s1_sig_b   <= sig_of(b);
      s1_sig_c   <= sig_of(c);
      s1_sign_ab <= a[FW-1] ^ b[FW-1];
      s1_eff_sub <= a[FW-1] ^ b[FW-1] ^ c[FW-1];
      s1_ec      <= exp_of(c);
      s1_exp_ab  <= exp_ab_c;
    end
  end

  // Stage 2: registered outputs; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sig_a    <= '0;
      out_sig_b    <= '0;
      out_sig_c    <= '0;
      out_shamt    <= '0;
      out_exp_ab   <= '0;
      out_sign_ab  <= 1'b0;
      out_eff_sub  <= 1'b0;
      out_clamp_lo <= 1'b0;
      out_clamp_hi <= 1'b0;
    end else begin
      if (adv2) out_valid <= v1;
      if (adv2 && v1) begin
        out_sig_a    <= s1_sig_a;
        out_sig_b    <= s1_sig_b;
        out_sig_c    <= s1_sig_c;
        out_shamt    <= shamt_c;
        out_exp_ab   <= s1_exp_ab;
        out_sign_ab  <= s1_sign_ab;
        out_eff_sub  <= s1_eff_sub;
        out_clamp_lo <= clamp_lo_c;
        out_clamp_hi <= clamp_hi_c;
      end
    end
  end

  // out_valid mirrors the stage-2 valid bit.
  logic unused_v2_alias;
  assign unused_v2_alias = v2 ^ out_valid;

endmodule

// File: tb/tb_align_shamt_pipe.sv
// Self-checking bench for align_shamt_pipe: directed and random triples
// against an arithmetic reference model and a 2-deep, 2-cycle queue model.
module tb_align_shamt_pipe;

  localparam int RES_W = 93;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic [23:0] out_sig_a, out_sig_b, out_sig_c;
  logic [6:0]  out_shamt;
  logic [9:0]  out_exp_ab;
  logic        out_sign_ab, out_eff_sub, out_clamp_lo, out_clamp_hi;

  align_shamt_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .out_sig_a(out_sig_a), .out_sig_b(out_sig_b), .out_sig_c(out_sig_c),
    .out_shamt(out_shamt), .out_exp_ab(out_exp_ab), .out_sign_ab(out_sign_ab),
    .out_eff_sub(out_eff_sub), .out_clamp_lo(out_clamp_lo),
    .out_clamp_hi(out_clamp_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  logic accepted;
  logic [RES_W-1:0] exp_q[$];
  int               acc_q[$];

  // Reference: IEEE field rules with plain integer arithmetic.
  function automatic logic [RES_W-1:0] model(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] z);
    int ex, ey, ez, pab, raw, sh;
    logic lo, hi;
    logic [23:0] sx, sy, sz;
    ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
    ez = (z[30:23] == 0) ? 1 : int'(z[30:23]);
    sx = {x[30:23] != 0, x[22:0]};
    sy = {y[30:23] != 0, y[22:0]};
    sz = {z[30:23] != 0, z[22:0]};
    pab = ex + ey - 127;
    raw = ez - pab + 27;
    lo = 1'b0; hi = 1'b0; sh = raw;
    if (raw < 0) begin sh = 0; lo = 1'b1; end
    else if (raw > 71) begin sh = 71; hi = 1'b1; end
    return {sx, sy, sz, 7'(sh), 10'(pab), x[31] ^ y[31], x[31] ^ y[31] ^ z[31], lo, hi};
  endfunction

  function automatic logic [RES_W-1:0] observed();
    return {out_sig_a, out_sig_b, out_sig_c, out_shamt, out_exp_ab,
            out_sign_ab, out_eff_sub, out_clamp_lo, out_clamp_hi};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
  endtask

  // One clock: check at negedge, book handshakes, then step past the edge.
  task automatic cycle();
    logic ev, er;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (cyc >= acc_q[0] + 2);
    er = !(exp_q.size() == 2 && !out_ready);
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("in_ready", 128'(in_ready), 128'(er));
    if (ev) begin
      chk("result", 128'(observed()), 128'(exp_q[0]));
      if (out_ready) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    accepted = in_valid && er;
    if (accepted) begin
      exp_q.push_back(model(a, b, c));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    case ($urandom_range(0, 4))
      0:       e = 8'($urandom_range(0, 255));
      1:       e = 8'h00;
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    chk(tag, 128'(exp_q.size()), 128'(0));
  endtask

  logic [31:0] da[5], db[5], dc[5];
  logic [31:0] sa[3], sb[3], sc[3];
  int idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_data", 128'(observed()), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Directed corner triples, each followed by idle cycles.
    da[0] = 32'h3F800000; db[0] = 32'h3F800000; dc[0] = 32'h3F800000;
    da[1] = 32'h3F800000; db[1] = 32'h3F800000; dc[1] = 32'h71800000;
    da[2] = 32'h64000000; db[2] = 32'h64000000; dc[2] = 32'h3F800000;
    da[3] = 32'hBF800000; db[3] = 32'h3F800000; dc[3] = 32'h00000000;
    da[4] = 32'h3F800000; db[4] = 32'h3F800000; dc[4] = 32'h00000001;
    for (int i = 0; i < 5; i++) begin
      a = da[i]; b = db[i]; c = dc[i]; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) cycle();
    end
    drain("drain_directed");

    // Back-to-back stream of 8 with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op(); in_valid = 1'b1;
      cycle();
    end
    drain("drain_stream");

    // Stall with 3 triples offered, then release.
    for (int i = 0; i < 3; i++) begin
      sa[i] = rnd_op(); sb[i] = rnd_op(); sc[i] = rnd_op();
    end
    idx = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = sa[idx]; b = sb[idx]; c = sc[idx]; in_valid = 1'b1;
      cycle();
      if (accepted) idx++;
    end
    chk("stall_accepted", 128'(idx), 128'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      a = sa[idx]; b = sb[idx]; c = sc[idx]; in_valid = 1'b1;
      cycle();
      if (accepted) idx++;
    end
    chk("stall_all_accepted", 128'(idx), 128'(3));
    drain("drain_stall");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    drain("drain_random");

    // Asynchronous reset while both stages are full.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op(); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    chk("full_before_reset", 128'(exp_q.size()), 128'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(1));
    chk("async_rst_data", 128'(observed()), 128'(0));
    exp_q.delete();
    acc_q.delete();
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    a = 32'h3F800000; b = 32'h40000000; c = 32'h3F800000; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("post_reset_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
